xadc_drp_scanner: RTL

//   DRP initiator for the XADC wizard. Replaces the fixed-address, eoc-looped-to-den hookup.

---
 rtl/xadc_drp_scanner.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/xadc_drp_scanner.sv
// rtl/xadc_drp_scanner.sv - XADC DRP initiator: writes the sequencer setup, then reads each converted channel into a table
module xadc_drp_scanner #(
    parameter logic [15:0] CFG_REG0    = 16'h0000,
    parameter logic [15:0] CFG_REG1    = 16'h2F0F,
    parameter logic [15:0] SEQ_CH0     = 16'h0800,
    parameter logic [15:0] SEQ_CH1     = 16'hFFF0,
    parameter int unsigned DRP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic [6:0]  drp_daddr,
    output logic        drp_den,
    output logic        drp_dwe,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    input  logic        xadc_eoc,
    input  logic [4:0]  xadc_channel,
    input  logic [4:0]  rd_sel,
    output logic [11:0] rd_data,
    output logic        sample_valid,
    output logic [4:0]  sample_ch,
    output logic [11:0] sample_data,
    output logic        cfg_done,
    output logic        drp_err,
    output logic        overrun
);

    typedef enum logic [2:0] {CFG_WR, CFG_WAIT, RUN_IDLE, RD, RD_WAIT} state_t;

    localparam logic [15:0] TMO = 16'(DRP_TIMEOUT);

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic [4:0]  ch_q, ch_d;
    logic        pend_valid_q, pend_valid_d;
    logic [4:0]  pend_ch_q, pend_ch_d;
    logic [6:0]  daddr_q, daddr_d;
    logic        den_q, den_d;
    logic        dwe_q, dwe_d;
    logic [15:0] di_q, di_d;
    logic        sample_valid_q, sample_valid_d;
    logic [4:0]  sample_ch_q, sample_ch_d;
    logic [11:0] sample_data_q, sample_data_d;
    logic        cfg_done_q, cfg_done_d;
    logic        drp_err_q, drp_err_d;
    logic        overrun_q, overrun_d;
    logic [11:0] rd_data_q, rd_data_d;
    logic [11:0] tab_q [32];
    logic [11:0] tab_d [32];

    logic [6:0]  cfg_addr;
    logic [15:0] cfg_val;
    logic        unused_do_lsb;

    assign unused_do_lsb = ^drp_do[3:0];

    always_comb begin
        cfg_addr = 7'h40;
        cfg_val  = CFG_REG0;
        case (idx_q)
            2'd0: begin cfg_addr = 7'h40; cfg_val = CFG_REG0; end
            2'd1: begin cfg_addr = 7'h41; cfg_val = CFG_REG1; end
            2'd2: begin cfg_addr = 7'h48; cfg_val = SEQ_CH0;  end
            default: begin cfg_addr = 7'h49; cfg_val = SEQ_CH1; end
        endcase
    end

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        cnt_d          = cnt_q;
        ch_d           = ch_q;
        pend_valid_d   = pend_valid_q;
        pend_ch_d      = pend_ch_q;
        daddr_d        = daddr_q;
        den_d          = 1'b0;
        dwe_d          = 1'b0;
        di_d           = di_q;
        sample_valid_d = 1'b0;
        sample_ch_d    = sample_ch_q;
        sample_data_d  = sample_data_q;
        cfg_done_d     = cfg_done_q;
        drp_err_d      = drp_err_q;
        overrun_d      = overrun_q;
        tab_d          = tab_q;
        rd_data_d      = tab_q[rd_sel];

        case (state_q)
            CFG_WR: begin
                daddr_d = cfg_addr;
                di_d    = cfg_val;
                den_d   = 1'b1;
                dwe_d   = 1'b1;
                cnt_d   = 16'd0;
                state_d = CFG_WAIT;
            end
            CFG_WAIT: begin
                // The first wait cycle is the den cycle itself; a drdy there is a stale one from before reset.
                if (drp_drdy && cnt_q != 16'd0) begin
                    if (idx_q == 2'd3) begin
                        cfg_done_d = 1'b1;
                        state_d    = RUN_IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = CFG_WR;
                    end
                end else if (cnt_q >= TMO) begin
                    drp_err_d = 1'b1;
                    state_d   = CFG_WR;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RUN_IDLE: begin
                if (pend_valid_q || xadc_eoc) begin
                    ch_d         = pend_valid_q ? pend_ch_q : xadc_channel;
                    daddr_d      = {2'b00, ch_d};
                    den_d        = 1'b1;
                    state_d      = RD;
                    pend_valid_d = pend_valid_q && xadc_eoc;
                    if (pend_valid_q && xadc_eoc) pend_ch_d = xadc_channel;
                end
            end
            RD: begin
                cnt_d   = 16'd1;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (drp_drdy) begin
                    tab_d[ch_q]    = drp_do[15:4];
                    sample_valid_d = 1'b1;
                    sample_ch_d    = ch_q;
                    sample_data_d  = drp_do[15:4];
                    state_d        = RUN_IDLE;
                end else if (cnt_q >= TMO) begin
                    drp_err_d = 1'b1;
                    state_d   = RUN_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = CFG_WR;
        endcase

        // eocs arriving while a read is in flight park in a single slot; the newest wins.
        if ((state_q == RD || state_q == RD_WAIT) && xadc_eoc) begin
            if (pend_valid_q) overrun_d = 1'b1;
            pend_valid_d = 1'b1;
            pend_ch_d    = xadc_channel;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= CFG_WR;
            idx_q          <= 2'd0;
            cnt_q          <= 16'd0;
            ch_q           <= 5'd0;
            pend_valid_q   <= 1'b0;
            pend_ch_q      <= 5'd0;
            daddr_q        <= 7'd0;
            den_q          <= 1'b0;
            dwe_q          <= 1'b0;
            di_q           <= 16'd0;
            sample_valid_q <= 1'b0;
            sample_ch_q    <= 5'd0;
            sample_data_q  <= 12'd0;
            cfg_done_q     <= 1'b0;
            drp_err_q      <= 1'b0;
            overrun_q      <= 1'b0;
            rd_data_q      <= 12'd0;
            tab_q          <= '{default: 12'd0};
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            ch_q           <= ch_d;
            pend_valid_q   <= pend_valid_d;
            pend_ch_q      <= pend_ch_d;
            daddr_q        <= daddr_d;
            den_q          <= den_d;
            dwe_q          <= dwe_d;
            di_q           <= di_d;
            sample_valid_q <= sample_valid_d;
            sample_ch_q    <= sample_ch_d;
            sample_data_q  <= sample_data_d;
            cfg_done_q     <= cfg_done_d;
            drp_err_q      <= drp_err_d;
            overrun_q      <= overrun_d;
            rd_data_q      <= rd_data_d;
            tab_q          <= tab_d;
        end
    end

    assign drp_daddr    = daddr_q;
    assign drp_den      = den_q;
    assign drp_dwe      = dwe_q;
    assign drp_di       = di_q;
    assign rd_data      = rd_data_q;
    assign sample_valid = sample_valid_q;
    assign sample_ch    = sample_ch_q;
    assign sample_data  = sample_data_q;
    assign cfg_done     = cfg_done_q;
    assign drp_err      = drp_err_q;
    assign overrun      = overrun_q;

endmodule
